// File: rtl/mem_port_arbiter.sv
// Unified memory-bus arbiter for the pipelined OTTER.
// Grants the single bus to either the MEM stage (data) or fetch (instruction),
// runs one req/ack transaction at a time, returns read data with a one-cycle
// valid pulse and stalls the pipeline while a requester waits. MEM always
// wins a simultaneous request.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  // fetch port
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IValid,
  // MEM-stage port
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  input  logic [1:0]  DSize,
  input  logic        DSign,
  output logic [31:0] DRdata,
  output logic        DValid,
  // memory bus
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWdata,
  output logic [1:0]  BusSize,
  output logic        BusSign,
  input  logic        BusAck,
  input  logic [31:0] BusRdata,
  // pipeline control
  output logic        StallF,
  output logic        StallM,
  output logic        BusErr
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIBusy = 2'd1,
    StDBusy = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
  // With the timeout disabled the counter just parks at all-ones.
  localparam logic [CNT_W-1:0] CntSat = (TIMEOUT_CYCLES == 0) ? {CNT_W{1'b1}} : TimeoutVal;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]  bus_size_q, bus_size_d;
  logic        bus_sign_q, bus_sign_d;

  logic [31:0] i_rdata_q, i_rdata_d;
  logic        i_valid_q, i_valid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_valid_q, d_valid_d;
  logic        bus_err_q, bus_err_d;

  // Saturating count of BUSY cycles, and the abort condition it feeds.
  always_comb begin
    cnt_inc     = (cnt_q == CntSat) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TimeoutVal);
  end

  // Next-state, bus sequencing and completion reporting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_size_d  = bus_size_q;
    bus_sign_d  = bus_sign_q;
    i_rdata_d   = i_rdata_q;
    i_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_valid_d   = 1'b0;
    bus_err_d   = bus_err_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // MEM holds the older instruction, so it is granted first.
        if (DReq) begin
          bus_req_d   = 1'b1;
          bus_we_d    = DWe;
          bus_addr_d  = DAddr;
          bus_wdata_d = DWdata;
          bus_size_d  = DSize;
          bus_sign_d  = DSign;
          state_d     = StDBusy;
        end else if (IReq) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = IAddr;
          bus_wdata_d = '0;
          bus_size_d  = 2'b10;
          bus_sign_d  = 1'b0;
          state_d     = StIBusy;
        end
      end

      StIBusy, StDBusy: begin
        cnt_d = cnt_inc;
        // An ack in the timeout cycle still counts as a good completion.
        if (BusAck || timeout_hit) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          cnt_d     = '0;
          if (state_q == StDBusy) begin
            d_valid_d = 1'b1;
            d_rdata_d = (BusAck && !bus_we_q) ? BusRdata : '0;
          end else begin
            i_valid_d = 1'b1;
            i_rdata_d = BusAck ? BusRdata : '0;
          end
          if (!BusAck) begin
            bus_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = StIdle;
        bus_req_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops BusReq immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_size_q  <= '0;
      bus_sign_q  <= 1'b0;
      i_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_size_q  <= bus_size_d;
      bus_sign_q  <= bus_sign_d;
      i_rdata_q   <= i_rdata_d;
      i_valid_q   <= i_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Output mapping and combinational stalls (fetch also freezes behind MEM).
  always_comb begin
    BusReq   = bus_req_q;
    BusWe    = bus_we_q;
    BusAddr  = bus_addr_q;
    BusWdata = bus_wdata_q;
    BusSize  = bus_size_q;
    BusSign  = bus_sign_q;
    IRdata   = i_rdata_q;
    IValid   = i_valid_q;
    DRdata   = d_rdata_q;
    DValid   = d_valid_q;
    BusErr   = bus_err_q;
    StallM   = DReq & ~d_valid_q;
    StallF   = (IReq & ~i_valid_q) | (DReq & ~d_valid_q);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned Tmo = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IReq, DReq, DWe, DSign, BusAck;
  logic [31:0] IAddr, DAddr, DWdata, BusRdata;
  logic [1:0]  DSize;
  logic [31:0] IRdata, DRdata, BusAddr, BusWdata;
  logic        IValid, DValid, BusReq, BusWe, BusSign, StallF, StallM, BusErr;
  logic [1:0]  BusSize;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES(Tmo),
    .CNT_W         (8)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .IReq    (IReq),
    .IAddr   (IAddr),
    .IRdata  (IRdata),
    .IValid  (IValid),
    .DReq    (DReq),
    .DWe     (DWe),
    .DAddr   (DAddr),
    .DWdata  (DWdata),
    .DSize   (DSize),
    .DSign   (DSign),
    .DRdata  (DRdata),
    .DValid  (DValid),
    .BusReq  (BusReq),
    .BusWe   (BusWe),
    .BusAddr (BusAddr),
    .BusWdata(BusWdata),
    .BusSize (BusSize),
    .BusSign (BusSign),
    .BusAck  (BusAck),
    .BusRdata(BusRdata),
    .StallF  (StallF),
    .StallM  (StallM),
    .BusErr  (BusErr)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model: one outstanding bus transaction, described by owner and age.
  bit          m_busy, m_own_d, m_iv, m_dv, m_err, m_we, m_sign;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  logic [1:0]  m_size;

  // Memory behaviour: ack on the ack_lat-th BUSY cycle (0 = never).
  int          ack_lat, lat_cfg;
  bit          fix_data, spurious;
  logic [31:0] fix_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own_d = 0; m_iv = 0; m_dv = 0; m_err = 0; m_age = 0;
    m_we = 0; m_sign = 0; m_addr = '0; m_wdata = '0; m_size = '0;
    m_ird = '0; m_drd = '0;
  endtask

  // Advance the model across one clock edge using this cycle's inputs.
  task automatic model_step(output bit granted);
    bit          done;
    logic [31:0] data;
    granted = 0;
    done    = 0;
    data    = '0;
    m_iv    = 0;
    m_dv    = 0;
    if (m_busy) begin
      m_age++;
      if (BusAck) begin
        done = 1;
        data = (m_own_d && m_we) ? 32'h0 : BusRdata;
      end else if (Tmo != 0 && m_age == Tmo) begin
        done  = 1;
        m_err = 1;
      end
      if (done) begin
        m_busy = 0;
        if (m_own_d) begin m_dv = 1; m_drd = data; end
        else begin m_iv = 1; m_ird = data; end
      end
    end else if (DReq) begin
      granted = 1; m_busy = 1; m_own_d = 1; m_age = 0;
      m_addr = DAddr; m_we = DWe; m_wdata = DWdata; m_size = DSize; m_sign = DSign;
    end else if (IReq) begin
      granted = 1; m_busy = 1; m_own_d = 0; m_age = 0;
      m_addr = IAddr; m_we = 0; m_wdata = '0; m_size = 2'b10; m_sign = 0;
    end
  endtask

  // One clock: memory response, stall checks, model update, edge, output checks.
  task automatic tick();
    bit granted;
    BusAck   = 1'b0;
    BusRdata = fix_data ? fix_val : $urandom;
    if (m_busy && ack_lat != 0 && m_age + 1 == ack_lat) BusAck = 1'b1;
    else if (!m_busy && spurious && $urandom_range(3) == 0) BusAck = 1'b1;
    #1;
    check_eq("stall_m", 32'(StallM), 32'(DReq & ~m_dv));
    check_eq("stall_f", 32'(StallF), 32'((IReq & ~m_iv) | (DReq & ~m_dv)));
    model_step(granted);
    if (granted) ack_lat = (lat_cfg < 0) ? int'($urandom_range(1, Tmo + 1)) : lat_cfg;
    @(posedge CLK);
    #1;
    cyc++;
    check_eq("bus_req", 32'(BusReq), 32'(m_busy));
    if (m_busy) begin
      check_eq("bus_addr", BusAddr, m_addr);
      check_eq("bus_we", 32'(BusWe), 32'(m_we));
      check_eq("bus_wdata", BusWdata, m_wdata);
      check_eq("bus_size", 32'(BusSize), 32'(m_size));
      check_eq("bus_sign", 32'(BusSign), 32'(m_sign));
    end
    check_eq("i_valid", 32'(IValid), 32'(m_iv));
    check_eq("d_valid", 32'(DValid), 32'(m_dv));
    if (m_iv) check_eq("i_rdata", IRdata, m_ird);
    if (m_dv) check_eq("d_rdata", DRdata, m_drd);
    check_eq("bus_err", 32'(BusErr), 32'(m_err));
  endtask

  // Tick until the model expects the chosen valid pulse; n returns the tick count.
  task automatic wait_valid(input bit want_d, output int n);
    n = 0;
    while (!(want_d ? m_dv : m_iv) && n < 30) begin
      tick();
      n++;
    end
    check_eq("wait_valid", 32'(want_d ? m_dv : m_iv), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, hi, pulses, dcyc, icyc;
    bit  d_act, i_act, i_ghost;

    RST_N = 1'b0; IReq = 0; DReq = 0; DWe = 0; DSign = 0; DSize = '0;
    IAddr = '0; DAddr = '0; DWdata = '0; BusAck = 0; BusRdata = '0;
    lat_cfg = 1; ack_lat = 1; fix_data = 0; fix_val = '0; spurious = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_busreq", 32'(BusReq), 32'd0);
    check_eq("rst_ivalid", 32'(IValid), 32'd0);
    check_eq("rst_dvalid", 32'(DValid), 32'd0);
    check_eq("rst_err", 32'(BusErr), 32'd0);
    check_eq("rst_irdata", IRdata, 32'd0);
    check_eq("rst_drdata", DRdata, 32'd0);
    check_eq("rst_busaddr", BusAddr, 32'd0);
    RST_N = 1'b1;

    // Fetch only: ack on the 3rd BusReq cycle.
    lat_cfg = 3; fix_data = 1; fix_val = 32'h0050_0093;
    IAddr = 32'h100; IReq = 1;
    tick();
    check_eq("fetch_addr", BusAddr, 32'h100);
    check_eq("fetch_we", 32'(BusWe), 32'd0);
    wait_valid(0, n);
    check_eq("fetch_latency", n + 1, 32'd4);
    check_eq("fetch_data", IRdata, 32'h0050_0093);
    IReq = 0; fix_data = 0;
    tick();

    // Simultaneous requests: data first.
    lat_cfg = 2;
    DWe = 0; DAddr = 32'h2000; DSize = 2'b10; DSign = 0; DReq = 1;
    IAddr = 32'h104; IReq = 1;
    tick();
    check_eq("simul_first", BusAddr, 32'h2000);
    check_eq("simul_stallf", 32'(StallF), 32'd1);
    wait_valid(1, n);
    dcyc = cyc; DReq = 0;
    wait_valid(0, n);
    icyc = cyc; IReq = 0;
    check_eq("d_before_i", 32'(dcyc < icyc), 32'd1);
    tick();

    // Store with one-cycle ack.
    lat_cfg = 1;
    DWe = 1; DAddr = 32'h3004; DWdata = 32'hDEAD_BEEF; DSize = 2'b00; DSign = 0; DReq = 1;
    tick();
    check_eq("store_we", 32'(BusWe), 32'd1);
    check_eq("store_size", 32'(BusSize), 32'd0);
    check_eq("store_wdata", BusWdata, 32'hDEAD_BEEF);
    wait_valid(1, n);
    check_eq("store_rdata", DRdata, 32'd0);
    DReq = 0; DWe = 0;
    tick();

    // Timeout: load never acked.
    lat_cfg = 0;
    DAddr = 32'h4000; DSize = 2'b10; DReq = 1;
    n = 0; hi = 0;
    while (!m_dv && n < 30) begin
      tick();
      n++;
      if (BusReq) hi++;
    end
    check_eq("tmo_busy_cycles", hi, Tmo);
    check_eq("tmo_dvalid", 32'(DValid), 32'd1);
    check_eq("tmo_rdata", DRdata, 32'd0);
    check_eq("tmo_err", 32'(BusErr), 32'd1);
    DReq = 0;
    tick();
    lat_cfg = 2; IAddr = 32'h108; IReq = 1;
    wait_valid(0, n);
    IReq = 0;
    tick();
    check_eq("err_sticky", 32'(BusErr), 32'd1);

    // Reset during D_BUSY.
    lat_cfg = 0; DAddr = 32'h5000; DReq = 1;
    tick();
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("rst_mid_busreq", 32'(BusReq), 32'd0);
    check_eq("rst_mid_dvalid", 32'(DValid), 32'd0);
    DReq = 0; BusAck = 0;
    model_reset();
    @(posedge CLK);
    #1;
    check_eq("rst_hold_busreq", 32'(BusReq), 32'd0);
    check_eq("rst_hold_err", 32'(BusErr), 32'd0);
    RST_N = 1'b1;
    lat_cfg = 2; IAddr = 32'h200; IReq = 1;
    tick();
    check_eq("post_rst_addr", BusAddr, 32'h200);
    wait_valid(0, n);
    IReq = 0;
    tick();

    // Requester drops IReq mid-transaction; ack lands in the timeout cycle.
    lat_cfg = 4; IAddr = 32'h300; IReq = 1;
    tick();
    tick();
    IReq = 0;
    pulses = 0;
    repeat (8) begin
      tick();
      if (IValid) pulses++;
    end
    check_eq("drop_pulses", pulses, 32'd1);
    check_eq("drop_idle", 32'(BusReq), 32'd0);
    check_eq("drop_no_err", 32'(BusErr), 32'd0);

    // Random traffic with random latencies, timeouts and stray acks.
    lat_cfg = -1; spurious = 1;
    d_act = 0; i_act = 0; i_ghost = 0;
    repeat (600) begin
      if (m_dv) d_act = 0;
      if (m_iv) begin i_act = 0; i_ghost = 0; end
      if (!d_act && $urandom_range(2) == 0) begin
        d_act  = 1;
        DWe    = 1'($urandom_range(1));
        DAddr  = $urandom;
        DWdata = $urandom;
        DSize  = 2'($urandom_range(2));
        DSign  = 1'($urandom_range(1));
      end
      if (!i_act && !i_ghost && $urandom_range(1) == 0) begin
        i_act = 1;
        IAddr = $urandom & 32'hFFFF_FFFC;
      end
      if (i_act && m_busy && !m_own_d && $urandom_range(7) == 0) begin
        i_act = 0; i_ghost = 1;
      end
      DReq = d_act;
      IReq = i_act;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the pipelined OTTER's single unified memory bus between the fetch stage (instruction reads) and the MEM stage (loads and stores).
- Sequences each bus transaction with a req/ack handshake of variable latency.
- Returns read data to the winning requester and drives the stall signals that freeze the pipeline while a requester waits.
- The MEM stage always wins: it holds the older instruction, and fetch is stalled anyway while MEM is stalled.

Parameters:
- TIMEOUT_CYCLES, 64: number of BUSY cycles without BusAck before the transaction is aborted; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IReq  in  1  fetch requests an instruction word.
- IAddr  in  32  fetch address.
- IRdata  out  32  instruction word; valid only when IValid=1.
- IValid  out  1  one-cycle pulse: fetch transaction complete.
- DReq  in  1  MEM stage requests a load or store.
- DWe  in  1  1 = store, 0 = load.
- DAddr  in  32  data address.
- DWdata  in  32  store data.
- DSize  in  2  access size (funct3[1:0]).
- DSign  in  1  unsigned-load flag (funct3[2]).
- DRdata  out  32  load data; valid only when DValid=1.
- DValid  out  1  one-cycle pulse: data transaction complete.
- BusReq  out  1  bus transaction request, held high until ack or abort.
- BusWe  out  1  write enable.
- BusAddr  out  32  bus address.
- BusWdata  out  32  bus write data.
- BusSize  out  2  bus access size.
- BusSign  out  1  bus sign flag.
- BusAck  in  1  one-cycle completion strobe from memory.
- BusRdata  in  32  read data, valid in the BusAck cycle.
- StallF  out  1  stall the fetch stage.
- StallM  out  1  stall the MEM stage.
- BusErr  out  1  sticky timeout flag.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; all Bus* outputs, IValid, DValid, BusErr and the counter cleared; IRdata and DRdata cleared to 0.
- Reset mid-transaction drops BusReq immediately. No valid pulse is issued for the lost transaction.
- States: IDLE, I_BUSY, D_BUSY.
- IDLE:
  - If DReq, register DAddr, DWdata, DWe, DSize and DSign onto the Bus* outputs, set BusReq=1, go to D_BUSY.
  - Else if IReq, register IAddr with BusWe=0, BusSize=2'b10, BusSign=0, BusWdata=0, set BusReq=1, go to I_BUSY.
  - Else hold.
  - DReq and IReq in the same cycle: D wins; I stays pending.
- BUSY:
  - All Bus* outputs are held stable and the counter increments each cycle.
  - On BusAck=1:
    - Next edge: BusReq=0, state=IDLE, counter=0.
    - D_BUSY: DValid=1 for one cycle; DRdata = captured BusRdata for a load, 0 for a store.
    - I_BUSY: IValid=1 for one cycle; IRdata = captured BusRdata.
  - Timeout: TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with no ack.
    - Abort: BusReq=0, state=IDLE.
    - The owning valid pulses with data 0.
    - BusErr is set and stays set until reset.
  - BusAck while in IDLE is ignored.
- Latency:
  - Request sampled at edge 0; BusReq high from cycle 1.
  - Ack in cycle k gives the valid pulse in cycle k+1.
  - Minimum 2 cycles (ack in cycle 1).
  - After completion there is one IDLE cycle before the next grant; no back-to-back bus cycles.
- Stalls (combinational):
  - StallM = DReq & ~DValid.
  - StallF = (IReq & ~IValid) | StallM.
- Requester rules:
  - Req and its address/data are held stable until the matching valid pulse.
  - If Req drops mid-transaction, the transaction still completes and the valid pulse still occurs; the requester ignores it.
  - Req asserted in the cycle its valid pulses is treated as a new request, sampled in the next IDLE cycle.
- Widths: the counter saturates at TIMEOUT_CYCLES and never wraps.

Test Plan:
- Fetch only:
  - Stimulus: IReq=1, IAddr=0x100; memory acks on the 3rd BusReq cycle with 0x00500093.
  - Required: BusAddr=0x100, BusWe=0; IValid pulses one cycle after the ack with IRdata=0x00500093; StallF high until that cycle.
- Simultaneous requests:
  - Stimulus: IReq and DReq (load, DAddr=0x2000) raised in the same cycle.
  - Required: the first bus transaction is 0x2000 and DValid precedes IValid; StallF stays high throughout D_BUSY.
- Store:
  - Stimulus: DWe=1, DAddr=0x3004, DWdata=0xDEADBEEF, DSize=2'b00; ack after 1 cycle.
  - Required: BusWe=1, BusSize=0, BusWdata=0xDEADBEEF; DValid pulse with DRdata=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, load issued, no BusAck.
  - Required: BusReq falls after 4 BUSY cycles; DValid pulses with DRdata=0; BusErr=1 and stays 1 after further good transactions.
- Reset mid-transaction:
  - Stimulus: assert RST_N=0 asynchronously during D_BUSY.
  - Required: BusReq=0 before the next clock edge; no DValid; after release, a fresh IReq is served normally.
- Requester drop:
  - Stimulus: IReq deasserted while in I_BUSY.
  - Required: BusReq held until ack; IValid still pulses once; the arbiter returns to IDLE.
